// File: rtl/usb_resp_pkg.sv
// usb_resp_pkg: shared constants and types for the USB response transmitter.
//   - readback address map (also used by usb_resp_mux)
//   - FSM state encoding
//   - FRAME_LEN: bytes per frame. It is 7 when USB_RESP_CHKSUM_EN is defined
//     (a trailing XOR checksum byte is added) and 6 otherwise.
package usb_resp_pkg;

   localparam logic [7:0] ADDR_CH_SEL  = 8'h01;
   localparam logic [7:0] ADDR_SMP_NUM = 8'h02;
   localparam logic [7:0] ADDR_SMP_SPD = 8'h03;
   localparam logic [7:0] ADDR_STATUS  = 8'h05;
   localparam logic [7:0] ADDR_VERSION = 8'hFE;

`ifdef USB_RESP_CHKSUM_EN
   localparam int FRAME_LEN = 7;
`else
   localparam int FRAME_LEN = 6;
`endif

   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/usb_resp_tx_if.sv
// usb_resp_tx_if: request channel (register readback) plus byte stream
// towards the USB TX FIFO writer.
//   req_valid/req_addr/req_ready : read request handshake
//   tx_data/tx_valid/tx_ready    : byte stream, one byte per valid&&ready
// Modports: slave = the transmitter, master = requester + FIFO side.
interface usb_resp_tx_if;
   logic       req_valid;
   logic [7:0] req_addr;
   logic       req_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport slave (
      input  req_valid, req_addr, tx_ready,
      output req_ready, tx_data, tx_valid
   );

   modport master (
      output req_valid, req_addr, tx_ready,
      input  req_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/usb_resp_mux.sv
// usb_resp_mux: combinational register readback mux.
//   addr             : register address
//   adc_ch_sel       : channel select (returned zero-extended)
//   set_sample_num   : sample count setting
//   set_sample_speed : sample speed setting
//   status_word      : live status
//   data             : selected 32-bit value, ERR_DATA for unmapped addresses
module usb_resp_mux
   import usb_resp_pkg::*;
#(
   parameter logic [31:0] VERSION  = 32'h2021_0223,
   parameter logic [31:0] ERR_DATA = 32'hEEEE_EEEE
) (
   input  logic [7:0]  addr,
   input  logic [1:0]  adc_ch_sel,
   input  logic [31:0] set_sample_num,
   input  logic [31:0] set_sample_speed,
   input  logic [31:0] status_word,
   output logic [31:0] data
);

   always_comb begin
      data = ERR_DATA;
      case (addr)
         ADDR_CH_SEL:  data = {30'b0, adc_ch_sel};
         ADDR_SMP_NUM: data = set_sample_num;
         ADDR_SMP_SPD: data = set_sample_speed;
         ADDR_STATUS:  data = status_word;
         ADDR_VERSION: data = VERSION;
         default:      data = ERR_DATA;
      endcase
   end

endmodule

// File: rtl/usb_resp_tx.sv
// usb_resp_tx: serialises register readbacks and sample-done events into
// fixed byte frames {HEADER, addr, data[31:24..7:0] (, checksum)} on the
// byte stream of usb_resp_tx_if.
// Optional build macro: USB_RESP_CHKSUM_EN appends an XOR checksum over the
// address and the four data bytes.
//   clk, reset       : clock, asynchronous active-high reset
//   bus (slave)      : request handshake and TX byte stream
//   adc_ch_sel, set_sample_num, set_sample_speed, status_word : readback sources
//   sample_done      : one-cycle end-of-acquisition pulse, sample_cnt valid with it
//   busy             : frame in progress
//   frame_done       : one-cycle pulse after the last byte is accepted
//   evt_overrun      : sticky, an unsent event count was overwritten
//
// state | meaning
// IDLE  | waiting; pending event has priority over a read request
// SEND  | presenting frame bytes, advancing on tx_ready
// DONE  | one-cycle completion pulse, then back to IDLE
module usb_resp_tx
   import usb_resp_pkg::*;
#(
   parameter logic [7:0]  HEADER   = 8'hA5,
   parameter logic [31:0] VERSION  = 32'h2021_0223,
   parameter logic [7:0]  EVT_ADDR = 8'h80,
   parameter logic [31:0] ERR_DATA = 32'hEEEE_EEEE
) (
   input  logic              clk,
   input  logic              reset,
   usb_resp_tx_if.slave      bus,
   input  logic [1:0]        adc_ch_sel,
   input  logic [31:0]       set_sample_num,
   input  logic [31:0]       set_sample_speed,
   input  logic [31:0]       status_word,
   input  logic              sample_done,
   input  logic [31:0]       sample_cnt,
   output logic              busy,
   output logic              frame_done,
   output logic              evt_overrun
);

   localparam int FW = FRAME_LEN * 8;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   state_t           state_q, state_d;
   logic [FW-1:0]    frame_q, frame_d;
   logic [IDX_W-1:0] idx_q;
   logic             evt_pending_q;
   logic [31:0]      evt_cnt_q;
   logic             load_evt, load_req, accept;
   logic [31:0]      mux_data;
   logic [7:0]       ld_addr;
   logic [31:0]      ld_data;

   usb_resp_mux #(
      .VERSION  (VERSION),
      .ERR_DATA (ERR_DATA)
   ) u_mux (
      .addr             (bus.req_addr),
      .adc_ch_sel       (adc_ch_sel),
      .set_sample_num   (set_sample_num),
      .set_sample_speed (set_sample_speed),
      .status_word      (status_word),
      .data             (mux_data)
   );

   // The whole frame is snapshotted at load so source changes mid-frame
   // cannot leak into the bytes in flight.
   assign ld_addr = evt_pending_q ? EVT_ADDR : bus.req_addr;
   assign ld_data = evt_pending_q ? evt_cnt_q : mux_data;

`ifdef USB_RESP_CHKSUM_EN
   assign frame_d = {HEADER, ld_addr, ld_data,
                     ld_addr ^ ld_data[31:24] ^ ld_data[23:16] ^
                     ld_data[15:8] ^ ld_data[7:0]};
`else
   assign frame_d = {HEADER, ld_addr, ld_data};
`endif

   always_comb begin
      state_d  = state_q;
      load_evt = 1'b0;
      load_req = 1'b0;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (evt_pending_q) begin
               load_evt = 1'b1;
               state_d  = SEND;
            end else if (bus.req_valid) begin
               load_req = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               accept = 1'b1;
               if (idx_q == IDX_LAST) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         frame_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load_evt || load_req) begin
            frame_q <= frame_d;
            idx_q   <= '0;
         end else if (accept) begin
            frame_q <= frame_q << 8;
            idx_q   <= idx_q + 1'b1;
         end else if (state_q == DONE) begin
            idx_q   <= '0;
         end
      end
   end

   // A new pulse in the cycle the pending event is consumed simply re-arms
   // the pending flag; it is only an overrun if the old count was never sent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_pending_q <= 1'b0;
         evt_cnt_q     <= '0;
         evt_overrun   <= 1'b0;
      end else if (sample_done) begin
         evt_pending_q <= 1'b1;
         evt_cnt_q     <= sample_cnt;
         if (evt_pending_q && !load_evt) evt_overrun <= 1'b1;
      end else if (load_evt) begin
         evt_pending_q <= 1'b0;
      end
   end

   assign bus.req_ready = (state_q == IDLE) && !evt_pending_q;
   assign bus.tx_valid  = (state_q == SEND);
   assign bus.tx_data   = (state_q == SEND) ? frame_q[FW-1 -: 8] : 8'h00;
   assign busy          = (state_q != IDLE);
   assign frame_done    = (state_q == DONE);

endmodule

// File: tb/tb_usb_resp_tx.sv
module tb_usb_resp_tx;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  adc_ch_sel;
   logic [31:0] set_sample_num, set_sample_speed, status_word, sample_cnt;
   logic        sample_done;
   logic        busy, frame_done, evt_overrun;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef USB_RESP_CHKSUM_EN
   localparam int NB = 7;
`else
   localparam int NB = 6;
`endif

   logic [7:0] e [7];

   usb_resp_tx_if bus();

   usb_resp_tx dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus.slave),
      .adc_ch_sel       (adc_ch_sel),
      .set_sample_num   (set_sample_num),
      .set_sample_speed (set_sample_speed),
      .status_word      (status_word),
      .sample_done      (sample_done),
      .sample_cnt       (sample_cnt),
      .busy             (busy),
      .frame_done       (frame_done),
      .evt_overrun      (evt_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_exp(input logic [7:0] a, input logic [31:0] d, input logic [7:0] ck);
      e[0] = 8'hA5; e[1] = a;
      e[2] = d[31:24]; e[3] = d[23:16]; e[4] = d[15:8]; e[5] = d[7:0];
      e[6] = ck;
   endtask

   // Called at a negedge; returns at the negedge after the accept posedge.
   task automatic issue_req(input logic [7:0] a);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("req_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Receives NB bytes against e[]; toggle drives tx_ready 1,0,1,0...
   // Returns at the negedge after the last accepted byte, where frame_done
   // must be high.
   task automatic recv_frame(input string tag, input bit toggle);
      int i = 0;
      int cyc = 0;
      while (i < NB && cyc < 200) begin
         bus.tx_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         if (bus.tx_valid) begin
            check($sformatf("%s_b%0d", tag, i), {24'h0, bus.tx_data}, {24'h0, e[i]});
            if (bus.tx_ready) i++;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) check({tag, "_timeout"}, 32'd0, 32'd1);
      check({tag, "_fdone"}, {31'h0, frame_done}, 32'd1);
      check({tag, "_vld_off"}, {31'h0, bus.tx_valid}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_addr = 8'h00; bus.tx_ready = 1'b0;
      adc_ch_sel = 2'b10; set_sample_num = 32'd16384;
      set_sample_speed = 32'h0000_0064; status_word = 32'h1234_5678;
      sample_done = 1'b0; sample_cnt = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
      check("rst_tx_valid",  {31'h0, bus.tx_valid},  32'd0);
      check("rst_tx_data",   {24'h0, bus.tx_data},   32'h00);
      check("rst_busy",      {31'h0, busy},          32'd0);
      check("rst_fdone",     {31'h0, frame_done},    32'd0);
      check("rst_ovr",       {31'h0, evt_overrun},   32'd0);
      reset = 1'b0;
      @(negedge clk);

      // T1: sample count readback, ready held high; source changes mid-frame
      set_exp(8'h02, 32'h0000_4000, 8'h42);
      issue_req(8'h02);
      check("t1_lat_vld", {31'h0, bus.tx_valid}, 32'd1);
      check("t1_busy",    {31'h0, busy},         32'd1);
      set_sample_num = 32'hFFFF_FFFF;
      recv_frame("t1", 1'b0);
      @(negedge clk);
      check("t1_fdone_1cyc", {31'h0, frame_done}, 32'd0);
      check("t1_idle_ready", {31'h0, bus.req_ready}, 32'd1);

      // T2: version with tx_ready toggling
      bus.tx_ready = 1'b0;
      set_exp(8'hFE, 32'h2021_0223, 8'hDE);
      issue_req(8'hFE);
      recv_frame("t2", 1'b1);
      @(negedge clk);

      // T3: event pending while a request waits; event goes first
      sample_done = 1'b1; sample_cnt = 32'h0000_1000;
      @(negedge clk);
      sample_done = 1'b0; sample_cnt = 32'h0;
      check("t3_ready_lo", {31'h0, bus.req_ready}, 32'd0);
      fork
         issue_req(8'h05);
         begin
            set_exp(8'h80, 32'h0000_1000, 8'h90);
            recv_frame("t3_evt", 1'b0);
            check("t3_ready_done", {31'h0, bus.req_ready}, 32'd0);
            set_exp(8'h05, 32'h1234_5678, 8'h0D);
            recv_frame("t3_req", 1'b0);
         end
      join
      check("t3_ovr", {31'h0, evt_overrun}, 32'd0);
      @(negedge clk);

      // T4: two sample_done pulses during a busy frame -> one event, overrun
      bus.tx_ready = 1'b0;
      issue_req(8'h03);
      sample_done = 1'b1; sample_cnt = 32'd5;
      @(negedge clk);
      sample_cnt = 32'd9;
      @(negedge clk);
      sample_done = 1'b0; sample_cnt = 32'd0;
      check("t4_ovr_set", {31'h0, evt_overrun}, 32'd1);
      set_exp(8'h03, 32'h0000_0064, 8'h67);
      recv_frame("t4_req", 1'b0);
      set_exp(8'h80, 32'h0000_0009, 8'h89);
      recv_frame("t4_evt", 1'b0);
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("t4_no_extra", {31'h0, busy}, 32'd0);

      // T5: unmapped address
      set_exp(8'h33, 32'hEEEE_EEEE, 8'h33);
      issue_req(8'h33);
      recv_frame("t5", 1'b0);
      check("t5_ovr_sticky", {31'h0, evt_overrun}, 32'd1);
      @(negedge clk);

      // T6: reset during byte 3
      bus.tx_ready = 1'b1;
      issue_req(8'h01);
      check("t6_b0", {24'h0, bus.tx_data}, 32'hA5);
      @(negedge clk);
      check("t6_b1", {24'h0, bus.tx_data}, 32'h01);
      @(negedge clk);
      check("t6_b2", {24'h0, bus.tx_data}, 32'h00);
      bus.tx_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("t6_abort_vld",  {31'h0, bus.tx_valid}, 32'd0);
      check("t6_abort_busy", {31'h0, busy},         32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t6_no_fdone", {31'h0, frame_done}, 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      check("t6_ready", {31'h0, bus.req_ready}, 32'd1);
      check("t6_ovr_clr", {31'h0, evt_overrun}, 32'd0);
      set_exp(8'h01, 32'h0000_0002, 8'h03);
      issue_req(8'h01);
      recv_frame("t6_full", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
